// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter. Partial-word stores are
// performed as a read-modify-write against a full-word-write memory.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int IDLE_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_mask,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_mask,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [31:0]   m1_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    WAIT     = 2'd2,
    MERGE_WR = 2'd3
  } state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] mask);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = mask[i] ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [31:0] merge_word(input logic [3:0]  mask,
                                             input logic [31:0] new_word,
                                             input logic [31:0] old_word);
    logic [31:0] m;
    m = lane_mask(mask);
    return (new_word & m) | (old_word & ~m);
  endfunction

  state_t        state_r, state_s;
  logic          grant_s, winner_s;
  logic          owner_r, last_r, we_r;
  logic [3:0]    mask_r;
  logic [31:0]   wdata_r, old_r, wdata_hold_r, wr_word_s;
  logic [31:0]   rdata0_r, rdata1_r;
  logic [AW-1:0] addr_r;
  logic          done0_r, done1_r;
  logic          fin_s, rd_fin_s, old_ld_s;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

  // Round-robin pick among current requests; only IDLE accepts, never while in reset.
  always_comb begin
    grant_s  = 1'b0;
    winner_s = 1'b0;
    if (!rst && (state_r == IDLE) && (m0_req || m1_req)) begin
      grant_s = 1'b1;
      if (m0_req && m1_req) begin
        winner_s = ~last_r;
      end else begin
        winner_s = m1_req;
      end
    end else begin
      grant_s  = 1'b0;
      winner_s = 1'b0;
    end
  end

  assign m0_gnt = grant_s & ~winner_s;
  assign m1_gnt = grant_s & winner_s;

  // Next-state and memory-side strobes.
  always_comb begin
    state_s   = state_r;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    wr_word_s = wdata_hold_r;
    fin_s     = 1'b0;
    rd_fin_s  = 1'b0;
    old_ld_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r && (mask_r == 4'hF)) begin
          mem_ce    = 1'b1;
          mem_we    = 1'b1;
          wr_word_s = wdata_r;
          fin_s     = 1'b1;
          state_s   = IDLE;
        end else if (we_r && (mask_r == 4'h0)) begin
          fin_s   = 1'b1;
          state_s = IDLE;
        end else begin
          mem_ce  = 1'b1;
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (we_r) begin
          old_ld_s = 1'b1;
          state_s  = MERGE_WR;
        end else begin
          rd_fin_s = 1'b1;
          fin_s    = 1'b1;
          state_s  = IDLE;
        end
      end
      MERGE_WR: begin
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        wr_word_s = merge_word(mask_r, wdata_r, old_r);
        fin_s     = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command capture at grant; last_r starts opposite IDLE_PRIO so IDLE_PRIO wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= 1'b0;
      last_r  <= (IDLE_PRIO == 0) ? 1'b1 : 1'b0;
      we_r    <= 1'b0;
      mask_r  <= 4'h0;
      wdata_r <= 32'h0000_0000;
      addr_r  <= '0;
    end else if (grant_s) begin
      owner_r <= winner_s;
      last_r  <= winner_s;
      we_r    <= winner_s ? m1_we : m0_we;
      mask_r  <= winner_s ? m1_mask : m0_mask;
      wdata_r <= winner_s ? m1_wdata : m0_wdata;
      addr_r  <= winner_s ? {m1_addr[AW-1:2], 2'b00} : {m0_addr[AW-1:2], 2'b00};
    end else begin
      owner_r <= owner_r;
      last_r  <= last_r;
    end
  end

  // Old word for read-modify-write and last written word on the memory bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_r        <= 32'h0000_0000;
      wdata_hold_r <= 32'h0000_0000;
    end else begin
      if (old_ld_s) begin
        old_r <= mem_rdata;
      end else begin
        old_r <= old_r;
      end
      if (mem_we) begin
        wdata_hold_r <= wr_word_s;
      end else begin
        wdata_hold_r <= wdata_hold_r;
      end
    end
  end

  // Completion pulses and per-requester read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      rdata0_r <= 32'h0000_0000;
      rdata1_r <= 32'h0000_0000;
    end else begin
      done0_r <= fin_s & ~owner_r;
      done1_r <= fin_s & owner_r;
      if (rd_fin_s && !owner_r) begin
        rdata0_r <= mem_rdata & lane_mask(mask_r);
      end else begin
        rdata0_r <= rdata0_r;
      end
      if (rd_fin_s && owner_r) begin
        rdata1_r <= mem_rdata & lane_mask(mask_r);
      end else begin
        rdata1_r <= rdata1_r;
      end
    end
  end

  assign m0_done   = done0_r;
  assign m1_done   = done1_r;
  assign m0_rdata  = rdata0_r;
  assign m1_rdata  = rdata1_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wr_word_s;
  assign busy      = (state_r != IDLE);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL declare parameter AW, default 32, meaning the byte-address width of every addr port.
REQ-002 The block SHALL declare parameter IDLE_PRIO, default 0, meaning the requester index that wins the first contested cycle after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_req  input  1  requester 0 access request, held until m0_gnt.
REQ-006 m0_we  input  1  requester 0 write (1) / read (0).
REQ-007 m0_addr  input  AW  requester 0 byte address; bits [1:0] ignored.
REQ-008 m0_wdata  input  32  requester 0 store data.
REQ-009 m0_mask  input  4  requester 0 byte-lane mask, bit i = lane [8i+7:8i].
REQ-010 m0_gnt  output  1  requester 0 command accepted this cycle (combinational).
REQ-011 m0_done  output  1  requester 0 access complete, one-cycle registered pulse.
REQ-012 m0_rdata  output  32  requester 0 read data, valid with m0_done on reads.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_gnt, m1_done, m1_rdata  same directions, widths and meanings as m0_*, for requester 1.
REQ-014 mem_ce  output  1  memory enable.
REQ-015 mem_we  output  1  memory full-word write enable.
REQ-016 mem_addr  output  AW  word-aligned address {addr[AW-1:2],2'b00}.
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  memory read word, valid the cycle after mem_ce=1, mem_we=0.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, WAIT, MERGE_WR; only IDLE accepts commands.
REQ-021 In IDLE with any req high, exactly one gnt SHALL assert; addr, we, wdata, mask and winner index are latched at that edge; next state ACCESS.
REQ-022 Arbitration SHALL be round-robin: single request wins; both requesting, the index not granted last wins; pointer updates on every grant.
REQ-023 ACCESS, full write (mask 1111): mem_ce=1, mem_we=1, mem_wdata=latched wdata; next IDLE; done pulse on following cycle.
REQ-024 ACCESS, write with mask 0000: mem_ce=0, mem_we=0; next IDLE; done pulse on following cycle.
REQ-025 ACCESS, read or partial write: mem_ce=1, mem_we=0; next WAIT.
REQ-026 WAIT, read: mem_rdata captured into winner's rdata with lanes whose mask bit is 0 forced to 0; next IDLE; done with rdata on following cycle.
REQ-027 WAIT, partial write: mem_rdata captured as old word; next MERGE_WR.
REQ-028 MERGE_WR: mem_ce=1, mem_we=1, mem_wdata lane i = mask[i] ? wdata lane i : old lane i; next IDLE; done on following cycle.
REQ-029 Latency from gnt cycle T: full or empty-mask write done at T+2, read done at T+3, partial write done at T+4.
REQ-030 The done pulse cycle is IDLE, so a new grant MAY occur in the same cycle as done (back-to-back).
REQ-031 The done, rdata and gnt outputs of the non-winning requester SHALL stay 0 / unchanged.
REQ-032 Outside ACCESS and MERGE_WR, mem_ce=0 and mem_we=0; outside write cycles, mem_wdata holds its last value.
REQ-033 Requests arriving while busy SHALL be held off (gnt=0), never dropped.

Reset
REQ-034 While rst=1, the state SHALL be IDLE, and all gnt, done, mem_ce, mem_we and busy SHALL be 0, immediately and without a clock edge.
REQ-035 While rst=1, all rdata, mem_addr and mem_wdata SHALL be 0x00000000, and the arbitration pointer SHALL be such that IDLE_PRIO wins the next contest.
REQ-036 Reset mid-operation SHALL abort the access with no done pulse and no further memory write.

Verification
REQ-037 m0 read addr 0x10, mask 1111, mem word 0xDEADBEEF -> m0_gnt at T, mem_ce/addr 0x10 at T+1, m0_done with m0_rdata=0xDEADBEEF at T+3.
REQ-038 m1 write addr 0x22, mask 0011, wdata 0x0000ABCD, old word 0x11223344 -> read at T+1, write 0x1122ABCD to 0x20 at T+3, m1_done at T+4.
REQ-039 m0 and m1 request together repeatedly after reset -> grants alternate m0, m1, m0, m1; none lost.
REQ-040 m0 write mask 0000 -> no mem_ce at T+1, m0_done at T+2, memory unchanged.
REQ-041 Assert rst during WAIT of a partial write -> mem_we never asserts, no done pulse, busy=0 immediately, next request granted normally.
REQ-042 m0 full write with req held continuously -> second grant coincides with first done, giving one access per two cycles.
